arb_mux: RTL and testbench

Registered, arbitrated N-input multiplexer with valid/ready handshakes on every input and on the output. It selects one requesting input per cycle using round-robin or fixed-priority arbitration and captures that beat into a one-entry output register. It replaces the static select muxes wherever several producers share one consumer, for example writeback sources or memory-request sources. The select is generated internally, so no external `sel` is required.

---
 rtl/arb_mux.sv | 86 ++++++++
 tb/tb_arb_mux.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - Registered N-input arbitrated mux with valid/ready on every channel
// Round-robin or fixed-priority grant feeding a one-entry output register.
module arb_mux #(
  parameter int DWIDTH = 32,
  parameter int NUM_IN = 4,
  parameter int RR     = 1,
  parameter int SELW   = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*DWIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [DWIDTH-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SELW-1:0]          out_sel
);

  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]   out_sel_q, out_sel_d;
  logic              out_valid_q, out_valid_d;

  logic              load;
  logic              xfer;
  logic              gnt_found;
  logic [SELW-1:0]   gnt_idx;
  logic [SELW-1:0]   base;
  logic [SELW:0]     idx;

  assign load = !out_valid_q || out_ready;
  assign base = (RR != 0) ? ptr_q : '0;

  // Scan NUM_IN positions starting at base, wrapping; first requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = {1'b0, base} + (SELW+1)'(k);
      if (idx >= (SELW+1)'(NUM_IN)) idx = idx - (SELW+1)'(NUM_IN);
      if (!gnt_found && in_valid[idx[SELW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[SELW-1:0];
      end
    end
  end

  assign xfer     = gnt_found && load && !rst;
  assign in_ready = xfer ? (NUM_IN'(1) << gnt_idx) : '0;

  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = in_data[int'(gnt_idx)*DWIDTH +: DWIDTH];
      out_sel_d   = gnt_idx;
      out_valid_d = 1'b1;
      if (RR != 0) ptr_d = (gnt_idx == SELW'(NUM_IN-1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - Bench for arb_mux: round-robin and fixed-priority instances vs a reference model
// Directed steps followed by random traffic; both instances share the same inputs.
module tb_arb_mux;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic           out_ready;

  logic [N-1:0]   rr_ready, fp_ready;
  logic [W-1:0]   rr_data, fp_data;
  logic           rr_valid, fp_valid;
  logic [1:0]     rr_sel, fp_sel;

  int total = 0;
  int bad   = 0;

  int          m_ptr [2];
  bit          m_ov  [2];
  logic [31:0] m_od  [2];
  int          m_os  [2];

  always #5 clk = ~clk;

  arb_mux #(.DWIDTH(W), .NUM_IN(N), .RR(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rr_ready),
    .out_data(rr_data), .out_valid(rr_valid), .out_ready(out_ready), .out_sel(rr_sel));

  arb_mux #(.DWIDTH(W), .NUM_IN(N), .RR(0)) u_fp (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(fp_ready),
    .out_data(fp_data), .out_valid(fp_valid), .out_ready(out_ready), .out_sel(fp_sel));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Winner by the arbitration rule: first valid channel scanning from p modulo N.
  function automatic int winner(input logic [N-1:0] v, input int p, input bit rr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = rr ? (p + k) % N : k;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] chan(input int i);
    return in_data[i*W +: W];
  endfunction

  task automatic step();
    int g;
    bit ld;
    logic [N-1:0] exp_rdy;
    #1;
    for (int u = 0; u < 2; u++) begin
      ld = !m_ov[u] || out_ready;
      g = winner(in_valid, m_ptr[u], u == 0);
      exp_rdy = (rst || !ld || g < 0) ? '0 : N'(1 << g);
      if (u == 0) chk("rr_in_ready", {28'b0, rr_ready}, {28'b0, exp_rdy});
      else        chk("fp_in_ready", {28'b0, fp_ready}, {28'b0, exp_rdy});
    end
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      ld = !m_ov[u] || out_ready;
      g = winner(in_valid, m_ptr[u], u == 0);
      if (rst) begin
        m_ptr[u] = 0; m_ov[u] = 0; m_od[u] = 0; m_os[u] = 0;
      end else if (ld && g >= 0) begin
        m_od[u] = chan(g); m_os[u] = g; m_ov[u] = 1;
        if (u == 0) m_ptr[u] = (g + 1) % N;
      end else if (m_ov[u] && out_ready) begin
        m_ov[u] = 0;
      end
    end
    @(negedge clk);
    chk("rr_out_valid", {31'b0, rr_valid}, {31'b0, m_ov[0]});
    chk("rr_out_data",  rr_data, m_od[0]);
    chk("rr_out_sel",   {30'b0, rr_sel}, 32'(m_os[0]));
    chk("rr_ptr",       {30'b0, u_rr.ptr_q}, 32'(m_ptr[0]));
    chk("fp_out_valid", {31'b0, fp_valid}, {31'b0, m_ov[1]});
    chk("fp_out_data",  fp_data, m_od[1]);
    chk("fp_out_sel",   {30'b0, fp_sel}, 32'(m_os[1]));
    chk("fp_ptr",       {30'b0, u_fp.ptr_q}, 32'(m_ptr[1]));
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_ptr[u] = 0; m_ov[u] = 0; m_od[u] = 0; m_os[u] = 0;
    end
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA0 + 32'(i);

    // Reset held two cycles with every channel requesting.
    rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    step();
    step();
    chk("rst_out_data", rr_data, 32'h0);
    rst = 1'b0;

    // Round-robin saturation: first grant after reset is channel 0.
    for (int k = 0; k < 6; k++) begin
      step();
      chk("sat_sel",  {30'b0, rr_sel}, 32'(k % N));
      chk("sat_data", rr_data, 32'hA0 + 32'(k % N));
    end

    // Fixed priority: channel 1 beats channel 3 until it drops.
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fp_sel_1", {30'b0, fp_sel}, 32'd1);
    end
    in_valid = 4'b1000;
    step();
    chk("fp_sel_3", {30'b0, fp_sel}, 32'd3);

    // Backpressure on a beat from channel 2.
    in_data[2*W +: W] = 32'hDEADBEEF;
    in_valid = 4'b0100;
    step();
    out_ready = 1'b0;
    in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_data", rr_data, 32'hDEADBEEF);
      chk("bp_sel",  {30'b0, rr_sel}, 32'd2);
      chk("bp_ptr",  {30'b0, u_rr.ptr_q}, 32'd3);
    end
    out_ready = 1'b1;
    step();
    chk("bp_next_sel", {30'b0, rr_sel}, 32'd3);

    // Sparse wrap-around from ptr=3.
    in_valid = 4'b0100;
    step();
    in_valid = 4'b0101;
    step();
    chk("sparse_sel0", {30'b0, rr_sel}, 32'd0);
    chk("sparse_ptr1", {30'b0, u_rr.ptr_q}, 32'd1);
    step();
    chk("sparse_sel2", {30'b0, rr_sel}, 32'd2);

    // Reset while a beat is stalled.
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", {31'b0, rr_valid}, 32'd0);
    chk("mid_rst_ptr",   {30'b0, u_rr.ptr_q}, 32'd0);
    in_valid = 4'b0000;
    out_ready = 1'b1;
    step();

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
